// File: rtl/bisection_pkg.sv
// Shared definitions for the bisection search block.
// Holds the FSM state encoding and the default parameter values.
package bisection_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_DONE,
        S_FAIL
    } state_e;

    localparam int DEF_BUS_WIDTH = 10;
    localparam int DEF_TOL       = 1;

endpackage

// File: rtl/bisection_abs_err.sv
// Signed difference (measured - desired) and its magnitude, both W+1 bits wide.
// Purely combinational; the magnitude always fits because both inputs are unsigned W-bit values.
module bisection_abs_err #(
    parameter int W = 10
) (
    input  logic [W-1:0]      meas_i,
    input  logic [W-1:0]      des_i,
    output logic signed [W:0] diff_o,
    output logic [W:0]        abs_o
);

    assign diff_o = $signed({1'b0, meas_i}) - $signed({1'b0, des_i});
    assign abs_o  = diff_o[W] ? $unsigned(-diff_o) : $unsigned(diff_o);

endmodule

// File: rtl/bisection_search.sv
// Bisection search driving a probe i_ref until the plant measurement matches the target.
// Optional stall detection is enabled by defining BISECTION_STALL_DET_EN.
module bisection_search
    import bisection_pkg::*;
#(
    parameter  int BUS_WIDTH = DEF_BUS_WIDTH,
    parameter  int TOL       = DEF_TOL,
    parameter  int MAX_ITER  = BUS_WIDTH + 2,
    parameter  int INVERT    = 0,
    localparam int IW        = $clog2(MAX_ITER + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 start,
    input  logic                 ready,
    input  logic [BUS_WIDTH-1:0] q_desired,
    input  logic [BUS_WIDTH-1:0] q_measured,
    output logic [BUS_WIDTH-1:0] i_ref,
    output logic                 busy,
    output logic                 converged,
    output logic                 went_unstable,
    output logic                 fail,
    output logic [IW-1:0]        iter_count
);

    localparam int W = BUS_WIDTH;
    localparam logic [W-1:0] B_INIT = '1;
    localparam logic [W-1:0] MID0   = B_INIT >> 1;
    localparam logic [W:0]   TOL_V  = (W + 1)'(TOL);

    state_e        state_q;
    logic [W-1:0]  a_q, b_q, i_ref_q, qd_q;
    logic [IW-1:0] iter_q;
    logic          conv_q, fail_q;

    logic signed [W:0] diff;
    logic [W:0]        err;

    bisection_abs_err #(.W(W)) u_abs_err (
        .meas_i (q_measured),
        .des_i  (qd_q),
        .diff_o (diff),
        .abs_o  (err)
    );

    logic          accept, drv_rdy, hit, go_up, empty, out_of_iter, stall;
    logic [W:0]    a_up, b_dn;
    logic [W-1:0]  a_nx, b_nx, mid_nx;
    logic [IW-1:0] iter_nx;

    assign accept  = enable && start && (state_q != S_DRIVE);
    assign drv_rdy = enable && !start_acc_block() && (state_q == S_DRIVE) && ready;
    assign hit     = err < TOL_V;
    assign go_up   = (diff < 0) ^ (INVERT != 0);
    assign a_up    = {1'b0, i_ref_q} + 1'b1;
    assign b_dn    = {1'b0, i_ref_q} - 1'b1;
    assign empty   = go_up ? (a_up > {1'b0, b_q})
                           : (b_dn[W] || ({1'b0, a_q} > b_dn));
    assign a_nx    = go_up ? a_up[W-1:0] : a_q;
    assign b_nx    = go_up ? b_q : b_dn[W-1:0];
    assign mid_nx  = a_nx + ((b_nx - a_nx) >> 1);
    assign iter_nx = iter_q + 1'b1;
    assign out_of_iter = (iter_nx == IW'(MAX_ITER));

    // start is never accepted in DRIVE, so it never masks a ready there
    function automatic logic start_acc_block();
        return 1'b0;
    endfunction

`ifdef BISECTION_STALL_DET_EN
    logic [W:0] h0_q, h1_q;
    logic [1:0] hv_q;
    logic       unst_q;

    assign stall = hv_q[0] && hv_q[1] && (err == h0_q) && (err == h1_q);

    // Error history: current err plus the two previous ones form the stall window
    always_ff @(posedge clk) begin
        if (rst || !enable || accept) begin
            h0_q   <= '0;
            h1_q   <= '0;
            hv_q   <= '0;
            unst_q <= 1'b0;
        end else if (drv_rdy) begin
            h1_q <= h0_q;
            h0_q <= err;
            hv_q <= {hv_q[0], 1'b1};
            if (!hit && stall)
                unst_q <= 1'b1;
        end
    end

    assign went_unstable = unst_q;
`else
    assign stall         = 1'b0;
    assign went_unstable = 1'b0;
`endif

    // Search FSM: interval bounds, probe, iteration count and result flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= B_INIT;
            i_ref_q <= MID0;
            qd_q    <= '0;
            iter_q  <= '0;
            conv_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else if (!enable) begin
            state_q <= S_IDLE;
            conv_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else if (accept) begin
            state_q <= S_DRIVE;
            a_q     <= '0;
            b_q     <= B_INIT;
            i_ref_q <= MID0;
            qd_q    <= q_desired;
            iter_q  <= '0;
            conv_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else if (drv_rdy) begin
            iter_q <= iter_nx;
            if (hit) begin
                state_q <= S_DONE;
                conv_q  <= 1'b1;
            end else if (stall || empty || out_of_iter) begin
                state_q <= S_FAIL;
                fail_q  <= 1'b1;
            end else begin
                a_q     <= a_nx;
                b_q     <= b_nx;
                i_ref_q <= mid_nx;
            end
        end
    end

    assign i_ref      = i_ref_q;
    assign busy       = (state_q == S_DRIVE);
    assign converged  = conv_q;
    assign fail       = fail_q;
    assign iter_count = iter_q;

endmodule

// File: tb/tb_bisection_search.sv
// Scoreboard bench for bisection_search: directed searches against simple plant models.
// Expected results are queued at start; a monitor pops them when a search ends.
module tb_bisection_search;

    logic       clk = 1'b0;
    logic       rst, enable;
    logic       start, ready, start_n, ready_n;
    logic [9:0] qd, qm, qm_n;
    logic [9:0] i_ref, i_ref_n;
    logic       busy, conv, unst, fl;
    logic       busy_n, conv_n, unst_n, fl_n;
    logic [3:0] iter, iter_n;

    always #5 clk = ~clk;

    bisection_search #(.BUS_WIDTH(10), .TOL(1), .INVERT(0)) dut (
        .clk(clk), .rst(rst), .enable(enable), .start(start), .ready(ready),
        .q_desired(qd), .q_measured(qm), .i_ref(i_ref), .busy(busy),
        .converged(conv), .went_unstable(unst), .fail(fl), .iter_count(iter)
    );

    bisection_search #(.BUS_WIDTH(10), .TOL(1), .INVERT(1)) dut_inv (
        .clk(clk), .rst(rst), .enable(enable), .start(start_n), .ready(ready_n),
        .q_desired(qd), .q_measured(qm_n), .i_ref(i_ref_n), .busy(busy_n),
        .converged(conv_n), .went_unstable(unst_n), .fail(fl_n), .iter_count(iter_n)
    );

    typedef struct {
        int conv;
        int fl;
        int unst;
        int iref;
        int iter;
    } exp_t;

    exp_t sbq[$];
    int   checks   = 0;
    int   failures = 0;
    bit   end_m    = 1'b0;
    bit   end_n    = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic pop_cmp(input bit inv);
        exp_t e;
        if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_unexpected_end actual=%0d required=0", inv);
        end else begin
            e = sbq.pop_front();
            if (inv) begin
                chk("inv_converged", conv_n, e.conv);
                chk("inv_fail", fl_n, e.fl);
                chk("inv_unstable", unst_n, e.unst);
                chk("inv_i_ref", i_ref_n, e.iref);
                chk("inv_iter", iter_n, e.iter);
            end else begin
                chk("converged", conv, e.conv);
                chk("fail", fl, e.fl);
                chk("unstable", unst, e.unst);
                chk("i_ref", i_ref, e.iref);
                chk("iter", iter, e.iter);
            end
        end
    endtask

    // Monitor: a search result is presented when converged or fail rises
    always @(negedge clk) begin
        if ((conv || fl) && !end_m)
            pop_cmp(1'b0);
        end_m = conv || fl;
        if ((conv_n || fl_n) && !end_n)
            pop_cmp(1'b1);
        end_n = conv_n || fl_n;
    end

    function automatic logic [9:0] plant(input int mode);
        case (mode)
            1:       return i_ref | 10'd1;
            2:       return 10'd50;
            default: return i_ref;
        endcase
    endfunction

    task automatic run_search(input int q, input int mode, input exp_t e);
        bit done = 1'b0;
        @(negedge clk);
        qd = 10'(q);
        sbq.push_back(e);
        if (mode == 3) start_n = 1'b1;
        else           start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        start_n = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (!((mode == 3) ? busy_n : busy)) begin
                done = 1'b1;
                break;
            end
            qm   = plant(mode);
            qm_n = 10'd1023 - i_ref_n;
            @(negedge clk);
            if (mode == 3) ready_n = 1'b1;
            else           ready   = 1'b1;
            @(negedge clk);
            ready   = 1'b0;
            ready_n = 1'b0;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL search_timeout actual=busy required=idle q=%0d", q);
        end
        repeat (2) @(negedge clk);
        chk("sb_drain", sbq.size(), 0);
    endtask

    task automatic do_readies(input int n);
        for (int k = 0; k < n; k++) begin
            qm = i_ref;
            @(negedge clk);
            ready = 1'b1;
            @(negedge clk);
            ready = 1'b0;
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_i_ref"}, i_ref, 511);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_conv"}, conv, 0);
        chk({tag, "_fail"}, fl, 0);
        chk({tag, "_unst"}, unst, 0);
        chk({tag, "_iter"}, iter, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; enable = 1'b1;
        start = 1'b0; ready = 1'b0; start_n = 1'b0; ready_n = 1'b0;
        qd = '0; qm = '0; qm_n = '0;
        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst = 1'b0;

        run_search(300, 0, '{1, 0, 0, 300, 10});
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("done_hold_conv", conv, 1);
        chk("done_hold_iref", i_ref, 300);
        chk("done_hold_iter", iter, 10);

        run_search(1023, 0, '{1, 0, 0, 1023, 11});
        run_search(0, 0, '{1, 0, 0, 0, 10});
        enable = 1'b0;
        @(negedge clk);
        chk("en_low_done_conv", conv, 0);
        chk("en_low_done_iref", i_ref, 0);
        enable = 1'b1;

        run_search(100, 3, '{1, 0, 0, 923, 8});
        run_search(400, 1, '{0, 1, 0, 400, 10});
`ifdef BISECTION_STALL_DET_EN
        run_search(500, 2, '{0, 1, 1, 895, 3});
`else
        run_search(500, 2, '{0, 1, 0, 1023, 11});
`endif

        @(negedge clk);
        qd = 10'd300;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        do_readies(2);
        qm = i_ref;
        @(negedge clk);
        ready = 1'b1;
        rst   = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        rst   = 1'b0;
        chk_reset("rst_mid");

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        do_readies(2);
        chk("mid_iref", i_ref, 383);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_start_ign_iref", i_ref, 383);
        chk("busy_start_ign_iter", iter, 2);
        enable = 1'b0;
        @(negedge clk);
        chk("en_low_busy", busy, 0);
        chk("en_low_conv", conv, 0);
        chk("en_low_fail", fl, 0);
        chk("en_low_unst", unst, 0);
        chk("en_low_iref", i_ref, 383);
        enable = 1'b1;
        repeat (2) @(negedge clk);
        chk("final_drain", sbq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
